// File: rtl/ascon_enc_host_if.sv
// ascon_enc_host_if: serial lanes and handshake between the host driver and the Ascon device
interface ascon_enc_host_if;
    logic       dev_rst;
    logic [2:0] keyxSI;
    logic [2:0] noncexSI;
    logic [2:0] associated_dataxSI;
    logic [2:0] plain_textxSI;
    logic [6:0] r_64xSI;
    logic       r_128xSI;
    logic       r_ptxSI;
    logic       encryption_startxSI;
    logic       cipher_textxSO;
    logic       tagxSO;
    logic       encryption_readyxSO;
    modport master (
        output dev_rst, keyxSI, noncexSI, associated_dataxSI, plain_textxSI,
        output r_64xSI, r_128xSI, r_ptxSI, encryption_startxSI,
        input  cipher_textxSO, tagxSO, encryption_readyxSO
    );
    modport slave (
        input  dev_rst, keyxSI, noncexSI, associated_dataxSI, plain_textxSI,
        input  r_64xSI, r_128xSI, r_ptxSI, encryption_startxSI,
        output cipher_textxSO, tagxSO, encryption_readyxSO
    );
endinterface

// File: rtl/ascon_enc_host.sv
// ascon_enc_host: streams operands MSB-first to the serial Ascon device and collects ciphertext/tag LSB-first
module ascon_enc_host #(
    parameter int          K       = 128,
    parameter int          L       = 80,
    parameter int          Y       = 80,
    parameter logic [31:0] SEED    = 32'hACE1_0001,
    parameter int          TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [K-1:0]      key_in,
    input  logic [127:0]      nonce_in,
    input  logic [L-1:0]      ad_in,
    input  logic [Y-1:0]      pt_in,
    output logic [Y-1:0]      ct_out,
    output logic [127:0]      tag_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    ascon_enc_host_if.master  bus
);
    localparam int KM = K > 128 ? K : 128;
    localparam int LY = L > Y ? L : Y;
    localparam int M  = KM > LY ? KM : LY;
    localparam int C  = Y > 128 ? Y : 128;
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT = 3'd2, START = 3'd3, CAPTURE = 3'd4;
    logic [2:0]   state;
    logic [31:0]  n, t, m, lfsr, lfsr_nx;
    logic [K-1:0] key_sr;
    logic [127:0] nonce_sr;
    logic [L-1:0] ad_sr;
    logic [Y-1:0] pt_sr;
    logic         rdy_d, ld;
    // Galois form of x^32 + x^22 + x^2 + x + 1
    assign lfsr_nx = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & 32'h8020_0003);
    assign ld      = state == LOAD;
    assign busy    = state != IDLE;
    assign bus.keyxSI             = ld ? {lfsr[1:0], key_sr[K-1]}   : 3'b0;
    assign bus.noncexSI           = ld ? {lfsr[3:2], nonce_sr[127]} : 3'b0;
    assign bus.associated_dataxSI = ld ? {lfsr[5:4], ad_sr[L-1]}    : 3'b0;
    assign bus.plain_textxSI      = ld ? {lfsr[7:6], pt_sr[Y-1]}    : 3'b0;
    assign bus.r_64xSI            = ld ? lfsr[14:8] : 7'b0;
    assign bus.r_128xSI           = ld & lfsr[15];
    assign bus.r_ptxSI            = ld & lfsr[16];
    assign bus.encryption_startxSI = state == START;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.dev_rst <= 1'b1;
            lfsr        <= SEED;
            n           <= '0;
            t           <= '0;
            m           <= '0;
            rdy_d       <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            ct_out      <= '0;
            tag_out     <= '0;
            key_sr      <= '0;
            nonce_sr    <= '0;
            ad_sr       <= '0;
            pt_sr       <= '0;
        end else begin
            done  <= 1'b0;
            rdy_d <= bus.encryption_readyxSO;
            case (state)
                IDLE: if (go) begin
                    key_sr      <= key_in;
                    nonce_sr    <= nonce_in;
                    ad_sr       <= ad_in;
                    pt_sr       <= pt_in;
                    timeout_err <= 1'b0;
                    ct_out      <= '0;
                    tag_out     <= '0;
                    n           <= '0;
                    bus.dev_rst <= 1'b0;
                    state       <= LOAD;
                end
                LOAD: begin
                    key_sr   <= key_sr << 1;
                    nonce_sr <= nonce_sr << 1;
                    ad_sr    <= ad_sr << 1;
                    pt_sr    <= pt_sr << 1;
                    lfsr     <= lfsr_nx;
                    n        <= n + 1;
                    if (n == M - 1) state <= WAIT;
                end
                WAIT: begin
                    n     <= n + 1;
                    t     <= '0;
                    state <= START;
                end
                START:
                    if (bus.encryption_readyxSO) begin
                        m     <= '0;
                        state <= CAPTURE;
                    end else if (t == TIMEOUT - 1) begin
                        timeout_err <= 1'b1;
                        bus.dev_rst <= 1'b1;
                        state       <= IDLE;
                    end else t <= t + 1;
                // results arrive LSB-first, so shift in from the top
                CAPTURE: if (rdy_d) begin
                    if (m < Y) ct_out <= {bus.cipher_textxSO, ct_out[Y-1:1]};
                    if (m < 128) tag_out <= {bus.tagxSO, tag_out[127:1]};
                    m <= m + 1;
                    if (m == C - 1) begin
                        done        <= 1'b1;
                        bus.dev_rst <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ascon_enc_host.md
Name: ascon_enc_host

Overview:
- Host-side driver for the serial Ascon encryption wrapper.
- Takes parallel operands, holds the device in reset while idle, and releases it to start a job.
- Streams key, nonce, associated data and plaintext MSB-first on the 3-bit serial lanes, together with LFSR randomness, then asserts start.
- Deserialises the LSB-first ciphertext and tag streams back into parallel registers and flags completion; used in SoC integration and as the bench-side transmitter/receiver.

Parameters:
- K, 128, key length in bits.
- L, 80, associated-data length in bits.
- Y, 80, plaintext/ciphertext length in bits.
- SEED, 32'hACE1_0001, LFSR reset seed; must be nonzero.
- TIMEOUT, 4096, max cycles in START waiting for encryption_readyxSO.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- go  in  1  one-cycle request; sampled only in IDLE.
- key_in  in  K  key.
- nonce_in  in  128  nonce.
- ad_in  in  L  associated data.
- pt_in  in  Y  plaintext.
- dev_rst  out  1  registered reset driven to the device.
- keyxSI  out  3  [0] key bit, [2:1] random shares.
- noncexSI  out  3  [0] nonce bit, [2:1] random shares.
- associated_dataxSI  out  3  [0] AD bit, [2:1] random shares.
- plain_textxSI  out  3  [0] PT bit, [2:1] random shares.
- r_64xSI  out  7  randomness lanes.
- r_128xSI  out  1  fault randomness, 128-bit lane.
- r_ptxSI  out  1  fault randomness, PT lane.
- encryption_startxSI  out  1  start request to the device.
- cipher_textxSO  in  1  serial ciphertext from the device.
- tagxSO  in  1  serial tag from the device.
- encryption_readyxSO  in  1  device result-ready.
- ct_out  out  Y  captured ciphertext.
- tag_out  out  128  captured tag.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the job completes.
- timeout_err  out  1  sticky error flag; cleared by the next accepted go.

Behaviour:
- Reset values: dev_rst=1, all serial outputs 0, encryption_startxSI=0, ct_out=0, tag_out=0, busy=0, done=0, timeout_err=0, LFSR=SEED, state=IDLE.
- M = max(K,128,L,Y), computed at elaboration. Counter n is 32 bits.
- IDLE:
  - dev_rst=1.
  - On go: latch operands into left-shift registers, clear timeout_err, set n=0, go to LOAD.
  - dev_rst goes to 0 on the same edge, so the first device edge with rst low sees n=0.
  - go in any other state is ignored.
- LOAD (n=0..M-1):
  - Lane bit0 outputs = MSB of each shift register: key_in[K-1-n] for n<K, else 0. Nonce, AD and PT follow the same rule with widths 128, L and Y.
  - Shift registers move left by 1 each cycle.
  - LFSR: 32-bit Galois, taps 32,22,2,1, steps every LOAD cycle. Bit mapping: lfsr[1:0] to keyxSI[2:1], [3:2] to noncexSI[2:1], [5:4] to associated_dataxSI[2:1], [7:6] to plain_textxSI[2:1], [14:8] to r_64xSI, [15] to r_128xSI, [16] to r_ptxSI. Lanes are 0 outside LOAD.
  - When n=M-1, go to WAIT.
- WAIT: exactly one cycle (device needs i>M). Then go to START.
- START:
  - encryption_startxSI=1 as a level, held until encryption_readyxSO is sampled high; then it drops and the state goes to CAPTURE.
  - A cycle counter counts START cycles. When it reaches TIMEOUT: set timeout_err=1, drop start, set dev_rst=1, go to IDLE. No done pulse is issued.
- CAPTURE:
  - rdy_d = encryption_readyxSO delayed by one cycle. The device registers bit j one cycle after its ready cycle.
  - On each cycle with rdy_d=1 and m<max(Y,128): ct_out[m]<=cipher_textxSO if m<Y; tag_out[m]<=tagxSO if m<128; m++.
  - encryption_readyxSO is treated as sticky. If it drops mid-capture, capture pauses and m holds.
  - After the capture at m=max(Y,128)-1: done=1 for one cycle, dev_rst=1, go to IDLE.
  - ct_out and tag_out hold their values until the next accepted go, which clears them.
- rst in any state: immediate return to reset values, including dev_rst=1; the device job is aborted.

Test Plan:
- Timing, K=L=Y=128, key=0x000102030405060708090A0B0C0D0E0F, go at cycle 10:
  - dev_rst=0 from cycle 11.
  - keyxSI[0] bits for n=0..7 are 0,0,0,0,0,0,0,0, and bits n=120..127 are 0,0,0,0,1,1,1,1.
  - START is entered at n=129.
- Default params (L=Y=80), ad_in=80'hFFFF_FFFF_FFFF_FFFF_FFFF:
  - associated_dataxSI[0]=1 for n=0..79, then 0 for n=80..127.
  - LOAD lasts exactly 128 cycles.
- Mock device raises ready 20 cycles after start, driving ct=0xA5A5 repeated and tag=0x0123456789ABCDEF0123456789ABCDEF:
  - ct_out and tag_out match.
  - done pulses once, 129 cycles after ready rises.
  - encryption_startxSI drops the cycle after ready.
- Mock device never raises ready, TIMEOUT=16:
  - timeout_err=1 after 16 START cycles, dev_rst=1, state IDLE, done never pulses.
  - Next go clears timeout_err.
- rst asserted at n=50 of LOAD: next cycle all serial outputs 0, dev_rst=1, busy=0, LFSR=SEED. A second go while busy is ignored (n is not reset).
